// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and sequencer for the 8-bit peripheral IO bus: grants one
// master, issues a single-cycle strobe, waits the read latency, then acks.
module io_bus_arbiter #(
  parameter int unsigned MASTERS    = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [MASTERS-1:0]     m_req_i,
  input  logic [MASTERS-1:0]     m_we_i,
  input  logic [8*MASTERS-1:0]   m_addr_i,
  input  logic [8*MASTERS-1:0]   m_wdata_i,
  output logic [MASTERS-1:0]     m_ack_o,
  output logic [7:0]             m_rdata_o,
  output logic [7:0]             io_addr_o,
  output logic [7:0]             io_out_o,
  output logic                   io_write_o,
  output logic                   io_read_o,
  input  logic [7:0]             io_in_i,
  output logic                   busy_o,
  output logic [1:0]             grant_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [MASTERS-1:0] ack_q, ack_d;

  always_comb begin
    int unsigned idx;
    int unsigned win;
    logic        found;
    logic [MASTERS-1:0] req_sh;
    logic [MASTERS-1:0] we_sh;

    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ack_d   = '0;
    idx     = 0;
    win     = 0;
    found   = 1'b0;
    req_sh  = '0;
    we_sh   = '0;

    unique case (state_q)
      IDLE: begin
        // Search begins one past the last grant and wraps; with one master this
        // degenerates to always picking master 0.
        for (int unsigned i = 1; i <= MASTERS; i++) begin
          idx    = (int'(last_q) + i) % MASTERS;
          req_sh = m_req_i >> idx;
          if (!found && req_sh[0]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          we_sh   = m_we_i >> win;
          grant_d = 2'(win);
          we_d    = we_sh[0];
          addr_d  = 8'(m_addr_i >> (8 * win));
          wdata_d = 8'(m_wdata_i >> (8 * win));
          wr_d    = we_sh[0];
          rd_d    = !we_sh[0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || RD_LATENCY == 0) begin
          if (!we_q) rdata_d = io_in_i;
          ack_d   = MASTERS'(1) << grant_q;
          state_d = ACK;
        end else begin
          cnt_d   = 2'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = io_in_i;
          ack_d   = MASTERS'(1) << grant_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'(MASTERS - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
    end
  end

  assign m_ack_o    = ack_q;
  assign m_rdata_o  = rdata_q;
  assign io_addr_o  = addr_q;
  assign io_out_o   = wdata_q;
  assign io_write_o = wr_q;
  assign io_read_o  = rd_q;
  assign busy_o     = (state_q != IDLE);
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: a transaction-level round-robin model
// predicts strobe/ack cycles and data; a monitor compares against the DUT.
module tb_io_bus_arbiter;
  localparam int unsigned M = 3;
  localparam int unsigned L = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [M-1:0]     req, we;
  logic [8*M-1:0]   addr_b, wdata_b;
  logic [M-1:0]     ack;
  logic [7:0]       rdata, io_addr, io_out, io_in;
  logic             io_wr, io_rd, busy;
  logic [1:0]       grant;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  io_bus_arbiter #(.MASTERS(M), .RD_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(req), .m_we_i(we), .m_addr_i(addr_b), .m_wdata_i(wdata_b),
    .m_ack_o(ack), .m_rdata_o(rdata),
    .io_addr_o(io_addr), .io_out_o(io_out),
    .io_write_o(io_wr), .io_read_o(io_rd), .io_in_i(io_in),
    .busy_o(busy), .grant_o(grant)
  );

  typedef struct {
    int         m;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         strobe;
    int         ackc;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rtab[256];
  int         last, free_c;
  logic [7:0] mrd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Peripheral side: valid read data only in the cycle RD_LATENCY after the strobe.
  int         pend = 0;
  logic [7:0] paddr;
  initial io_in = '0;
  always @(negedge clk) begin
    io_in = 8'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) io_in = rtab[paddr];
    end
    if (!rst_n) pend = 0;
    else if (io_rd) begin
      if (L == 0) io_in = rtab[io_addr];
      else begin
        pend  = L;
        paddr = io_addr;
      end
    end
  end

  // Monitor
  initial begin
    bit h;
    bit eb, ew, er;
    int ea;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) continue;
      h  = (q.size() > 0);
      eb = h && cyc >= q[0].strobe && cyc <= q[0].ackc;
      chk("busy", int'(busy), int'(eb));
      ew = h && cyc == q[0].strobe && q[0].we;
      er = h && cyc == q[0].strobe && !q[0].we;
      if (ew || er || io_wr || io_rd) begin
        chk("io_write", int'(io_wr), int'(ew));
        chk("io_read", int'(io_rd), int'(er));
        if (ew || er) chk("io_addr", int'(io_addr), int'(q[0].addr));
        if (ew) chk("io_out", int'(io_out), int'(q[0].wdata));
      end
      ea = (h && cyc == q[0].ackc) ? (1 << q[0].m) : 0;
      if (ea != 0 || ack != '0) begin
        chk("m_ack", int'(ack), ea);
        if (ea != 0) begin
          chk("grant", int'(grant), q[0].m);
          chk("m_rdata", int'(rdata), int'(q[0].rdata));
          chk("io_addr_hold", int'(io_addr), int'(q[0].addr));
        end
      end
      if (h && cyc >= q[0].ackc) void'(q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int rr(input int lg, input logic [M-1:0] mask);
    for (int i = 1; i <= int'(M); i++) begin
      int idx;
      idx = (lg + i) % int'(M);
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_master(input int k, input bit w, input logic [7:0] a, input logic [7:0] d);
    we[k]             = w;
    addr_b[8*k +: 8]  = a;
    wdata_b[8*k +: 8] = d;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_wr"}, int'(io_wr), 0);
    chk({tag, "_rd"}, int'(io_rd), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_addr"}, int'(io_addr), 0);
    chk({tag, "_out"}, int'(io_out), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_grant"}, int'(grant), 0);
  endtask

  task automatic model_reset_release();
    rst_n  = 1'b1;
    last   = M - 1;
    free_c = cyc;
    mrd    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    model_reset_release();
  endtask

  // One arbitration round from the current request set; called at a negedge.
  task automatic do_txn(input bit drop, input bit rereq, input bit scramble);
    int   n, w;
    exp_t e;
    n = (cyc > free_c) ? cyc : free_c;
    w = rr(last, req);
    e.m     = w;
    e.we    = we[w];
    e.addr  = addr_b[8*w +: 8];
    e.wdata = wdata_b[8*w +: 8];
    if (!e.we) mrd = rtab[e.addr];
    e.rdata  = mrd;
    e.strobe = n + 1;
    e.ackc   = n + 2 + (e.we ? 0 : int'(L));
    q.push_back(e);
    wait_cyc(e.strobe);
    if (drop) req[w] = 1'b0;
    else if (scramble) set_master(w, 1'($urandom), 8'($urandom), 8'($urandom));
    wait_cyc(e.ackc);
    if (!rereq) req[w] = 1'b0;
    last   = w;
    free_c = e.ackc + 1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rtab[i] = 8'($urandom);
    rtab[8'h22] = 8'h3C;
    req = '0; we = '0; addr_b = '0; wdata_b = '0;
    rst_n = 1'b0;
    last = M - 1; free_c = 0; mrd = '0;

    repeat (5) begin
      @(negedge clk);
      req     = M'($urandom);
      we      = M'($urandom);
      addr_b  = (8*M)'($urandom);
      wdata_b = (8*M)'($urandom);
      #1;
      check_reset("rst");
    end
    @(negedge clk);
    req = '0;
    model_reset_release();

    // Single write, then read with latency, then a write that must not touch rdata
    @(negedge clk);
    set_master(0, 1'b1, 8'h10, 8'hA5); req[0] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);
    set_master(1, 1'b0, 8'h22, 8'h00); req[1] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);
    set_master(2, 1'b1, 8'h30, 8'h5A); req[2] = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0);

    // Contention from reset: masters 0 and 1 keep requesting
    do_reset();
    set_master(0, 1'($urandom), 8'($urandom), 8'($urandom));
    set_master(1, 1'($urandom), 8'($urandom), 8'($urandom));
    req = 3'b011;
    repeat (4) do_txn(1'b0, 1'b1, 1'b1);
    req = '0;

    // Reset abort during WAIT, then the still-pending read completes
    set_master(1, 1'b0, 8'($urandom), 8'h00); req[1] = 1'b1;
    n = (cyc > free_c) ? cyc : free_c;
    q.push_back('{m: 1, we: 1'b0, addr: addr_b[15:8], wdata: 8'h00,
                  rdata: rtab[addr_b[15:8]], strobe: n + 1, ackc: n + 2 + int'(L)});
    wait_cyc(n + 2);
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset("abort");
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_rd", int'(io_rd), 0);
      chk("abort_ack", int'(ack), 0);
    end
    @(negedge clk);
    model_reset_release();
    do_txn(1'b0, 1'b0, 1'b0);

    // Withdrawal in the ACCESS cycle: ack still comes, nothing further starts
    set_master(0, 1'b1, 8'h44, 8'h99); req[0] = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Randomized traffic
    repeat (150) begin
      if (req == '0) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        for (int k = 0; k < int'(M); k++)
          if ($urandom_range(0, 1) == 1) begin
            set_master(k, 1'($urandom), 8'($urandom), 8'($urandom));
            req[k] = 1'b1;
          end
        if (req == '0) begin
          set_master(0, 1'($urandom), 8'($urandom), 8'($urandom));
          req[0] = 1'b1;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, M - 1);
        if (!req[k]) begin
          set_master(k, 1'($urandom), 8'($urandom), 8'($urandom));
          req[k] = 1'b1;
        end
      end
      do_txn($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'($urandom));
    end
    req = '0;
    repeat (4) @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Round-robin arbiter and sequencer for the 8-bit peripheral IO bus of the arduFPGA SoC. It lets up to four bus masters share one `io_addr`/`io_out`/`io_write`/`io_read`/`io_in` bus: the RISC-V core's IO port, a debug/loader port and future DMA. It grants one master at a time, issues a single-cycle read or write strobe, waits a fixed peripheral read latency, then returns a one-cycle acknowledge with read data. It sits between the masters and the existing IO peripheral decode (LED/RGB, timers, etc.).

## Interface
- `MASTERS`, default 2: number of requesters, legal range 1–4.
- `RD_LATENCY`, default 1: cycles from the `io_read_o` strobe cycle to the cycle in which `io_in_i` is valid, legal range 0–3.

Ports:
- `clk_i` in 1: single system clock; all logic on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `m_req_i` in MASTERS: per-master request level.
- `m_we_i` in MASTERS: per-master, 1 = write, 0 = read.
- `m_addr_i` in 8*MASTERS: per-master address; master k uses bits [8k+7:8k].
- `m_wdata_i` in 8*MASTERS: per-master write data, same packing as `m_addr_i`.
- `m_ack_o` out MASTERS: one-cycle completion pulse to the granted master.
- `m_rdata_o` out 8: shared read-data return, valid while `m_ack_o` is high for a read.
- `io_addr_o` out 8: IO bus address.
- `io_out_o` out 8: IO bus write data.
- `io_write_o` out 1: one-cycle write strobe.
- `io_read_o` out 1: one-cycle read strobe.
- `io_in_i` in 8: IO bus read data.
- `busy_o` out 1: high in every state except IDLE.
- `grant_o` out 2: index of the current or last granted master.

## Operation
- FSM states: IDLE, ACCESS, WAIT, ACK.
- **IDLE**
  - If no `m_req_i` bit is set, stay in IDLE.
  - Otherwise pick the winner round-robin: search starts at `(last_grant+1) mod MASTERS` and moves upward with wrap-around.
  - Latch the winner's index, addr, wdata and we, then go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - Assert `io_write_o` if the latched we = 1, else assert `io_read_o`.
  - Write: next state is ACK.
  - Read with `RD_LATENCY`=0: capture `io_in_i` into `m_rdata_o` this cycle, next state is ACK.
  - Read with `RD_LATENCY`>0: next state is WAIT.
- **WAIT**
  - A counter runs for `RD_LATENCY` cycles.
  - On the last WAIT cycle, capture `io_in_i` into `m_rdata_o`, then go to ACK.
- **ACK** (exactly 1 cycle)
  - `m_ack_o[grant]`=1 and all other ack bits are 0.
  - Update `last_grant` to the latched index, then go to IDLE.
- Master rule: a master clears its `m_req_i` at the clock edge where it samples its ack. If `m_req_i` is still high in the following IDLE cycle, that is a new transaction.
- Request capture: all request fields are latched at grant. Changing or dropping `m_req_i` after the grant does not abort the transaction, and the ack is still issued.
- Bus hold: `io_addr_o` and `io_out_o` are driven from the latch and keep their last values outside ACCESS. `m_rdata_o` holds the last captured read value; a write does not change it.
- Arbitration with `MASTERS`=1: no round-robin, always master 0.
- Request bits at index ≥ `MASTERS` do not exist; the width is parameterised.

## Timing
- Reset values:
  - `m_ack_o`=0, `io_write_o`=0, `io_read_o`=0, `busy_o`=0.
  - `io_addr_o`=0x00, `io_out_o`=0x00, `m_rdata_o`=0x00, `grant_o`=0.
  - `last_grant`=`MASTERS`-1, so master 0 has first priority.
  - FSM in IDLE.
- Write: request seen in IDLE in cycle n → strobe in cycle n+1 → ack in cycle n+2.
- Read: strobe in cycle n+1 → `io_in_i` sampled in cycle n+1+`RD_LATENCY` → ack in cycle n+2+`RD_LATENCY`.
- Throughput: at most one transaction per 3+`RD_LATENCY` cycles, because IDLE always lasts at least one cycle between transactions.
- Simultaneous requests in IDLE: exactly one is granted; the others wait with no starvation. A master waits at most `MASTERS`-1 transactions.
- Reset asserted mid-transaction, in any state:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - No ack is issued for the aborted transaction.
  - After `rst_ni` deasserts, the first arbitration starts from master 0.
- `io_write_o` and `io_read_o` are never high together, and never high outside ACCESS.

## Test plan
- **Reset:** hold `rst_ni`=0 for 5 cycles with random request inputs → all outputs at reset values, no strobes.
- **Single write:** master 0 writes addr 0x10, data 0xA5, request in cycle n → cycle n+1 has `io_write_o`=1, `io_addr_o`=0x10, `io_out_o`=0xA5; cycle n+2 has `m_ack_o`=01. `busy_o` is high in cycles n+1 to n+2.
- **Read latency:** `RD_LATENCY`=2, master 1 reads addr 0x22, `io_in_i`=0x3C valid in strobe cycle+2 → `m_ack_o`=10 with `m_rdata_o`=0x3C in cycle n+4; `m_rdata_o` keeps 0x3C afterwards.
- **Contention:** from reset, masters 0 and 1 request together and both hold requests for 4 transactions → grant order 0,1,0,1; `grant_o` matches each ack.
- **Reset abort:** pull `rst_ni` low during WAIT → `io_read_o`/`m_ack_o` stay 0, FSM in IDLE; a pending request after release is granted and completes normally.
- **Request withdrawal:** master drops `m_req_i` in the ACCESS cycle → transaction still completes with an ack; no second transaction starts.
